// File: rtl/axi_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter_if
// Purpose  : Single read-channel bundle (address + response handshakes).
// Revision : 1.0
// ============================================================================
interface axi_rd_arbiter_if;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] araddr;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output ar_valid, araddr, r_ready,
        input  ar_ready, r_valid, rdata, rresp
    );

    modport slave (
        input  ar_valid, araddr, r_ready,
        output ar_ready, r_valid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : 2-master / 2-slave round-robin read arbiter with address decode.
// Revision : 1.0
// ============================================================================
module axi_rd_arbiter #(
    parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
    parameter logic [31:0] SRAM_SIZE  = 32'h0800_0000,
    parameter logic [31:0] CLINT_BASE = 32'hA000_0048,
    parameter logic [31:0] CLINT_SIZE = 32'd8
) (
    input  wire              clock,
    input  wire              reset,
    axi_rd_arbiter_if.slave  m0_io,
    axi_rd_arbiter_if.slave  m1_io,
    axi_rd_arbiter_if.master s0_io,
    axi_rd_arbiter_if.master s1_io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DERR = 2'd3
    } state_e;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q,  last_d;
    logic        sel_q,   sel_d;
    logic [31:0] addr_q,  addr_d;

    logic        win;
    logic [31:0] win_addr;
    logic        hit_clint;
    logic        hit_sram;
    logic        sel_ar_ready;
    logic        sel_r_valid;
    logic [31:0] sel_rdata;
    logic [1:0]  sel_rresp;
    logic        gnt_r_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;

    // Subtract-then-compare keeps the window test free of 32-bit overflow.
    always_comb begin
        win       = m1_io.ar_valid & (~m0_io.ar_valid | ~last_q);
        win_addr  = win ? m1_io.araddr : m0_io.araddr;
        hit_clint = (win_addr >= CLINT_BASE) && ((win_addr - CLINT_BASE) < CLINT_SIZE);
        hit_sram  = (win_addr >= SRAM_BASE)  && ((win_addr - SRAM_BASE)  < SRAM_SIZE);

        sel_ar_ready = sel_q ? s1_io.ar_ready : s0_io.ar_ready;
        sel_r_valid  = sel_q ? s1_io.r_valid  : s0_io.r_valid;
        sel_rdata    = sel_q ? s1_io.rdata    : s0_io.rdata;
        sel_rresp    = sel_q ? s1_io.rresp    : s0_io.rresp;
        gnt_r_ready  = grant_q ? m1_io.r_ready : m0_io.r_ready;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        sel_d   = sel_q;
        addr_d  = addr_q;

        m0_io.ar_ready = 1'b0;
        m1_io.ar_ready = 1'b0;
        s0_io.ar_valid = 1'b0;
        s1_io.ar_valid = 1'b0;
        s0_io.r_ready  = 1'b0;
        s1_io.r_ready  = 1'b0;
        s0_io.araddr   = addr_q;
        s1_io.araddr   = addr_q;
        rsp_valid      = 1'b0;
        rsp_data       = 32'h0;
        rsp_resp       = 2'b00;

        // Outputs are held quiet for as long as reset is asserted.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    m0_io.ar_ready = m0_io.ar_valid & ~win;
                    m1_io.ar_ready = win;
                    if (m0_io.ar_valid | m1_io.ar_valid) begin
                        grant_d = win;
                        addr_d  = win_addr;
                        sel_d   = hit_clint;
                        state_d = (hit_clint | hit_sram) ? SEND : DERR;
                    end
                end
                SEND: begin
                    s0_io.ar_valid = ~sel_q;
                    s1_io.ar_valid = sel_q;
                    if (sel_ar_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    rsp_valid     = sel_r_valid;
                    rsp_data      = sel_rdata;
                    rsp_resp      = sel_rresp;
                    s0_io.r_ready = ~sel_q & gnt_r_ready;
                    s1_io.r_ready = sel_q & gnt_r_ready;
                    if (sel_r_valid & gnt_r_ready) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
                DERR: begin
                    rsp_valid = 1'b1;
                    rsp_resp  = RESP_DECERR;
                    if (gnt_r_ready) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        m0_io.r_valid = rsp_valid & ~grant_q;
        m1_io.r_valid = rsp_valid & grant_q;
        m0_io.rdata   = grant_q ? 32'h0 : rsp_data;
        m1_io.rdata   = grant_q ? rsp_data : 32'h0;
        m0_io.rresp   = grant_q ? 2'b00 : rsp_resp;
        m1_io.rresp   = grant_q ? rsp_resp : 2'b00;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
        end
    end

endmodule
`default_nettype wire
